// File: rtl/bpu_pkg.sv
// -----------------------------------------------------------------------------
// bpu_pkg
//   Shared types and constants for the branch predictor.
//   - BTB_IDX_W_DEFAULT : default BTB index width (2^6 = 64 entries)
//   - cnt_e             : 2-bit direction counter encodings SNT/WNT/WT/ST
//   - btb_entry_t       : one BTB entry {valid, tag, target, cnt}
//   - pc_tag()          : tag field of a PC for a given index width
//   The tag field is sized for the narrowest index (30 bits). Shorter tags
//   are stored zero-extended; the constant upper bits are trimmed by synthesis.
// -----------------------------------------------------------------------------
package bpu_pkg;

   localparam int BTB_IDX_W_DEFAULT = 6;
   localparam int TAG_W_MAX         = 30;
   localparam int NUM_PORTS         = 2;

   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } cnt_e;

   typedef struct packed {
      logic                 valid;
      logic [TAG_W_MAX-1:0] tag;
      logic [31:0]          target;
      logic [1:0]           cnt;
   } btb_entry_t;

   // tag = pc[31:idx_w+2], right-aligned
   function automatic logic [TAG_W_MAX-1:0] pc_tag(input logic [31:0] pc,
                                                   input int          idx_w);
      logic [31:0] sh;
      sh = pc >> (idx_w + 2);
      return sh[TAG_W_MAX-1:0];
   endfunction

endpackage

// File: rtl/bpu_sat_cnt.sv
// -----------------------------------------------------------------------------
// bpu_sat_cnt
//   Next-state logic of a 2-bit saturating direction counter.
//   Ports:
//     cnt     in  [1:0]  current counter
//     taken   in         resolved direction
//     cnt_nxt out [1:0]  counter after update (ST and SNT stick)
// -----------------------------------------------------------------------------
module bpu_sat_cnt
   import bpu_pkg::*;
(
   input  logic [1:0] cnt,
   input  logic       taken,
   output logic [1:0] cnt_nxt
);

   always_comb begin
      cnt_nxt = cnt;
      if (taken) begin
         if (cnt != ST) cnt_nxt = cnt + 2'd1;
      end else begin
         if (cnt != SNT) cnt_nxt = cnt - 2'd1;
      end
   end

endmodule

// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
//   Direct-mapped BTB with 2-bit counters, predicting a two-slot fetch group
//   (slot a = IF_pc, slot b = IF_pc+4) one cycle after the lookup.
//
//   Parameters:
//     BTB_IDX_W  index width, 2^BTB_IDX_W entries
//     INIT_CNT   counter value loaded by reset
//   Ports:
//     clk, rstn                  clock, async active-low reset
//     IF_valid/IF_stall/IF_flush lookup request, output hold, pending discard
//     IF_pc                      fetch group address
//     ID_pd_valid                prediction valid
//     ID_br_pd_a / ID_br_pd_b    slot a / slot b predicted taken
//     ID_pc_pd                   predicted next fetch address
//     EX_upd_*_{a,b}             resolved-branch update ports
//     stat_upd_cnt/stat_miss_cnt update and misprediction counters
//                                (only when BPU_STATS_EN is defined)
//
//   Build option: define BPU_STATS_EN to add the statistics counters.
//
//   Lookups read the table before this cycle's updates land, so a lookup
//   and an update of the same entry in one cycle see the old contents.
// -----------------------------------------------------------------------------
module branch_predictor
   import bpu_pkg::*;
#(
   parameter int         BTB_IDX_W = BTB_IDX_W_DEFAULT,
   parameter logic [1:0] INIT_CNT  = 2'b01
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        IF_valid,
   input  logic        IF_stall,
   input  logic        IF_flush,
   input  logic [31:0] IF_pc,
   output logic        ID_pd_valid,
   output logic        ID_br_pd_a,
   output logic        ID_br_pd_b,
   output logic [31:0] ID_pc_pd,
   input  logic        EX_upd_valid_a,
   input  logic [31:0] EX_upd_pc_a,
   input  logic        EX_upd_taken_a,
   input  logic [31:0] EX_upd_target_a,
   input  logic        EX_upd_pd_a,
   input  logic        EX_upd_valid_b,
   input  logic [31:0] EX_upd_pc_b,
   input  logic        EX_upd_taken_b,
   input  logic [31:0] EX_upd_target_b,
   input  logic        EX_upd_pd_b
`ifdef BPU_STATS_EN
   ,
   output logic [31:0] stat_upd_cnt,
   output logic [31:0] stat_miss_cnt
`endif
);

   localparam int ENTRIES = 1 << BTB_IDX_W;

   btb_entry_t tbl [ENTRIES];

   // ---------------------------------------------------------------- lookup
   logic [31:0]          pc_b;
   logic [BTB_IDX_W-1:0] idx_a, idx_b;
   btb_entry_t           ent_a, ent_b;
   logic                 tk_a, tk_b;
   logic [31:0]          npc;

   assign pc_b  = IF_pc + 32'd4;
   assign idx_a = IF_pc[BTB_IDX_W+1:2];
   assign idx_b = pc_b[BTB_IDX_W+1:2];
   assign ent_a = tbl[idx_a];
   assign ent_b = tbl[idx_b];

   // slot b is only reported when slot a falls through
   assign tk_a = ent_a.valid && (ent_a.tag == pc_tag(IF_pc, BTB_IDX_W)) && ent_a.cnt[1];
   assign tk_b = !tk_a && ent_b.valid && (ent_b.tag == pc_tag(pc_b, BTB_IDX_W)) && ent_b.cnt[1];
   assign npc  = tk_a ? ent_a.target :
                 tk_b ? ent_b.target :
                        IF_pc + 32'd8;

   // flush beats stall; stall holds everything; idle only drops valid
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ID_pd_valid <= 1'b0;
         ID_br_pd_a  <= 1'b0;
         ID_br_pd_b  <= 1'b0;
         ID_pc_pd    <= 32'h0;
      end else if (IF_flush) begin
         ID_pd_valid <= 1'b0;
         ID_br_pd_a  <= 1'b0;
         ID_br_pd_b  <= 1'b0;
      end else if (!IF_stall) begin
         if (IF_valid) begin
            ID_pd_valid <= 1'b1;
            ID_br_pd_a  <= tk_a;
            ID_br_pd_b  <= tk_b;
            ID_pc_pd    <= npc;
         end else begin
            ID_pd_valid <= 1'b0;
         end
      end
   end

   // ---------------------------------------------------------------- update
   logic [NUM_PORTS-1:0]                upd_vld, upd_tk, upd_pd;
   logic [NUM_PORTS-1:0][31:0]          upd_pc, upd_tgt;
   logic [NUM_PORTS-1:0][BTB_IDX_W-1:0] upd_idx;
   logic [NUM_PORTS-1:0]                upd_hit, upd_we;
   logic [NUM_PORTS-1:0][1:0]           upd_cnt_nxt;
   btb_entry_t [NUM_PORTS-1:0]          upd_old, upd_new;
   logic                                idx_clash;

   assign upd_vld = {EX_upd_valid_b,  EX_upd_valid_a};
   assign upd_tk  = {EX_upd_taken_b,  EX_upd_taken_a};
   assign upd_pd  = {EX_upd_pd_b,     EX_upd_pd_a};
   assign upd_pc  = {EX_upd_pc_b,     EX_upd_pc_a};
   assign upd_tgt = {EX_upd_target_b, EX_upd_target_a};

   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
      assign upd_idx[p] = upd_pc[p][BTB_IDX_W+1:2];
      assign upd_old[p] = tbl[upd_idx[p]];
      assign upd_hit[p] = upd_old[p].valid &&
                          (upd_old[p].tag == pc_tag(upd_pc[p], BTB_IDX_W));

      bpu_sat_cnt u_sat (
         .cnt     (upd_old[p].cnt),
         .taken   (upd_tk[p]),
         .cnt_nxt (upd_cnt_nxt[p])
      );

      // hit: step counter, refresh target only when taken
      // miss (written only when taken): fresh entry starting weakly taken
      assign upd_new[p] = '{valid:  1'b1,
                            tag:    pc_tag(upd_pc[p], BTB_IDX_W),
                            target: upd_tk[p] ? upd_tgt[p] : upd_old[p].target,
                            cnt:    upd_hit[p] ? upd_cnt_nxt[p] : WT};
   end

   // same-index pair: port a wins, even if it ends up writing nothing
   assign idx_clash = upd_vld[0] && upd_vld[1] && (upd_idx[0] == upd_idx[1]);
   assign upd_we[0] = upd_vld[0] && (upd_hit[0] || upd_tk[0]);
   assign upd_we[1] = upd_vld[1] && (upd_hit[1] || upd_tk[1]) && !idx_clash;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < ENTRIES; i++)
            tbl[i] <= '{valid: 1'b0, tag: '0, target: 32'h0, cnt: INIT_CNT};
      end else begin
         for (int p = 0; p < NUM_PORTS; p++)
            if (upd_we[p]) tbl[upd_idx[p]] <= upd_new[p];
      end
   end

   // ---------------------------------------------------------------- stats
`ifdef BPU_STATS_EN
   logic [1:0] n_upd, n_miss;
   logic [NUM_PORTS-1:0] miss_vec;

   assign miss_vec = upd_vld & (upd_pd ^ upd_tk);
   assign n_upd    = {1'b0, upd_vld[0]}  + {1'b0, upd_vld[1]};
   assign n_miss   = {1'b0, miss_vec[0]} + {1'b0, miss_vec[1]};

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         stat_upd_cnt  <= 32'h0;
         stat_miss_cnt <= 32'h0;
      end else begin
         stat_upd_cnt  <= stat_upd_cnt  + {30'b0, n_upd};
         stat_miss_cnt <= stat_miss_cnt + {30'b0, n_miss};
      end
   end
`else
   // carried predictions only feed the statistics
   logic unused_pd;
   assign unused_pd = ^upd_pd;
`endif

endmodule
